// File: rtl/ldm_stm_seq_pkg.sv
// Shared definitions for the block load/store sequencer: FSM state codes,
// the word size in bytes and a register-list population count.
package ldm_stm_seq_pkg;

  localparam int WORD_BYTES = 4;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_XFER = 2'd1;
  localparam state_t S_WB   = 2'd2;
  localparam state_t S_DONE = 2'd3;

  function automatic logic [4:0] popcount16(input logic [15:0] vec);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ldm_stm_seq_prio_enc.sv
// Lowest-set-bit priority encoder over the remaining register mask.
module ldm_prio_enc (
  input  logic [15:0] vec,
  output logic [3:0]  idx,
  output logic        valid
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    idx   = 4'd0;
    valid = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = 4'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM block transfer sequencer: walks the register list in ascending
// order, one memory beat per register, then optionally writes back the base.
module ldm_stm_seq
  import ldm_stm_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        is_load,
  input  logic        pre,
  input  logic        up,
  input  logic        wback,
  input  logic [3:0]  rn,
  input  logic [15:0] rlist,
  input  logic [31:0] base,
  input  logic        mem_ready,
  input  logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] addr,
  output logic [3:0]  ra,
  output logic        we,
  output logic [3:0]  wa,
  output logic [31:0] wd,
  output logic        bwe,
  output logic [3:0]  bwa,
  output logic [31:0] bwd,
  output logic        pc_we,
  output logic [31:0] pc_wd,
  output logic        busy,
  output logic        done
);

  state_t      state;
  logic        is_load_q;
  logic        up_q;
  logic        wback_q;
  logic [3:0]  rn_q;
  logic [15:0] rlist_q;
  logic [15:0] mask;
  logic [31:0] base_q;
  logic [31:0] cur_addr;
  logic [4:0]  cnt;

  logic [3:0]  cur_reg;
  logic        cur_valid;
  logic [4:0]  n_in;
  logic [31:0] span_in;
  logic [31:0] span;
  logic [31:0] start_addr;
  logic [15:0] mask_next;
  logic        in_xfer;
  logic        beat;
  logic        last_beat;
  logic        take_wb;
  logic        load_beat;

  ldm_prio_enc u_enc (
    .vec   (mask),
    .idx   (cur_reg),
    .valid (cur_valid)
  );

  assign n_in      = popcount16(rlist);
  assign span_in   = 32'(n_in) * 32'(WORD_BYTES);
  assign span      = 32'(cnt) * 32'(WORD_BYTES);
  assign in_xfer   = (state == S_XFER) && cur_valid;
  assign beat      = in_xfer && mem_ready;
  assign mask_next = mask & ~(16'd1 << cur_reg);
  assign last_beat = beat && (mask_next == 16'd0);
  // A loaded base register already holds its final value, so skip writeback.
  assign take_wb   = wback_q && !(is_load_q && rlist_q[rn_q]);
  assign load_beat = beat && is_load_q;

  always_comb begin
    case ({pre, up})
      2'b01:   start_addr = base;
      2'b11:   start_addr = base + 32'(WORD_BYTES);
      2'b00:   start_addr = base - span_in + 32'(WORD_BYTES);
      default: start_addr = base - span_in;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      is_load_q <= 1'b0;
      up_q      <= 1'b0;
      wback_q   <= 1'b0;
      rn_q      <= 4'd0;
      rlist_q   <= 16'd0;
      mask      <= 16'd0;
      base_q    <= 32'd0;
      cur_addr  <= 32'd0;
      cnt       <= 5'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            is_load_q <= is_load;
            up_q      <= up;
            wback_q   <= wback;
            rn_q      <= rn;
            rlist_q   <= rlist;
            mask      <= rlist;
            base_q    <= base;
            cur_addr  <= start_addr;
            cnt       <= n_in;
            state     <= (rlist != 16'd0) ? S_XFER : S_DONE;
          end
        end
        S_XFER: begin
          if (beat) begin
            mask     <= mask_next;
            cur_addr <= cur_addr + 32'(WORD_BYTES);
            if (last_beat) begin
              state <= take_wb ? S_WB : S_DONE;
            end
          end
        end
        S_WB:    state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign mem_req = in_xfer;
  assign mem_wr  = in_xfer && !is_load_q;
  assign addr    = in_xfer ? cur_addr : 32'd0;
  assign ra      = in_xfer ? cur_reg : 4'd0;
  assign we      = load_beat && (cur_reg != 4'd15);
  assign wa      = we ? cur_reg : 4'd0;
  assign wd      = we ? rdata : 32'd0;
  assign pc_we   = load_beat && (cur_reg == 4'd15);
  assign pc_wd   = pc_we ? rdata : 32'd0;
  assign bwe     = (state == S_WB);
  assign bwa     = bwe ? rn_q : 4'd0;
  assign bwd     = bwe ? (up_q ? base_q + span : base_q - span) : 32'd0;

endmodule
